canny_frame_streamer: RTL and testbench

//  Source end of the Canny pipeline's pixel input interface (in_data/enable).

---
 rtl/canny_pkg.sv | 28 ++
 rtl/canny_frame_streamer_if.sv | 36 +++
 rtl/canny_raster_counter.sv | 80 ++++++++
 rtl/canny_frame_streamer.sv | 169 ++++++++++++++++
 tb/tb_canny_frame_streamer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/canny_pkg.sv
// ---------------------------------------------------------------------------
// canny_pkg
// Shared definitions for the Canny pipeline's frame source and frame
// collector: default image geometry, pixel and address widths, the streaming
// FSM state encoding, and a counter-width helper.
// No ports (package).
// ---------------------------------------------------------------------------
package canny_pkg;

    localparam int IMG_W_DEFAULT  = 640;
    localparam int IMG_H_DEFAULT  = 512;
    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } stream_state_e;

    // Bits needed to count 0..n-1; never less than one so that degenerate
    // geometries (a one-pixel-wide image, a zero-length gap) still elaborate.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/canny_frame_streamer_if.sv
// ---------------------------------------------------------------------------
// canny_frame_streamer_if
// Bundles the two buses of the frame streamer:
//   - frame-buffer read port : mem_rd, mem_addr (out), mem_rdata (in)
//   - pixel stream           : out_data, out_en, frame_start, line_end (out)
// Modports:
//   master : the streamer side (drives reads and the pixel stream)
//   slave  : the frame buffer / pipeline side
//
// Transfer rules: the read port is a fixed-latency strobe, mem_rdata is valid
// exactly one cycle after mem_rd=1. The pixel stream is valid-only: a pixel is
// transferred on every cycle with out_en=1, there is no ready/backpressure,
// and frame_start/line_end are meaningful only when out_en=1.
// ---------------------------------------------------------------------------
interface canny_frame_streamer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_en;
    logic              frame_start;
    logic              line_end;

    modport master (
        output mem_rd, mem_addr, out_data, out_en, frame_start, line_end,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr, out_data, out_en, frame_start, line_end,
        output mem_rdata
    );
endinterface

// File: rtl/canny_raster_counter.sv
// ---------------------------------------------------------------------------
// canny_raster_counter
// Raster-order position tracker for one frame: column, row and linear
// frame-buffer address, advanced together one pixel at a time.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        return to pixel 0 (takes priority over advance)
//   advance      step to the next pixel in raster order
//   addr         current linear address (row*IMG_W + col)
//   first_pixel  current position is column 0 of row 0
//   last_col     current position is the last column of a line
//   last_pixel   current position is the last pixel of the frame
// ---------------------------------------------------------------------------
module canny_raster_counter
    import canny_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEFAULT,
    parameter int IMG_H  = IMG_H_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              first_pixel,
    output logic              last_col,
    output logic              last_pixel
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_row;

    assign last_col    = (col_q == COL_LAST);
    assign last_row    = (row_q == ROW_LAST);
    assign last_pixel  = last_col && last_row;
    assign first_pixel = (col_q == '0) && (row_q == '0);
    assign addr        = addr_q;

    // The address is its own incrementing counter rather than row*IMG_W+col,
    // so no multiplier sits in the read-address path.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (advance) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/canny_frame_streamer.sv
// ---------------------------------------------------------------------------
// canny_frame_streamer
// Source end of the Canny pipeline's pixel input. On start, reads one frame in
// raster order from a synchronous-read frame buffer and replays it as a
// cycle-exact pixel stream (out_data/out_en), with an optional idle gap after
// every line but the last, a level pause, and frame/line markers.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle frame request, honoured only in IDLE
//   pause       level; while high no new frame-buffer reads are issued
//   bus         master side of canny_frame_streamer_if (read port + stream)
//   busy        high from the accepted start until done
//   done        one-cycle pulse the cycle after the final pixel
//   dbg_state   current FSM state
// Timing: start sampled in cycle 0, read of address 0 in cycle 1, read data
// in cycle 2, first out_en in cycle 3; done follows the last out_en by one.
// ---------------------------------------------------------------------------
module canny_frame_streamer
    import canny_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEFAULT,
    parameter int IMG_H    = IMG_H_DEFAULT,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int LINE_GAP = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          pause,
    canny_frame_streamer_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output stream_state_e                 dbg_state
);

    localparam int GAP_W = cnt_width(LINE_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = (LINE_GAP > 0) ? GAP_W'(LINE_GAP - 1) : '0;

    stream_state_e     state_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              mem_rd;
    logic [ADDR_W-1:0] addr;
    logic              first_pixel;
    logic              last_col;
    logic              last_pixel;

    // Two-stage output pipe: stage 1 lines up with mem_rdata, stage 2 is the
    // registered stream. The markers travel with the read strobe.
    logic              rd_p1_q, rd_p1_d;
    logic              fs_p1_q, fs_p1_d;
    logic              le_p1_q, le_p1_d;
    logic              out_en_q, out_en_d;
    logic              fs_q, fs_d;
    logic              le_q, le_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    assign start_ok = (state_q == IDLE) && start;
    assign mem_rd   = (state_q == READ) && !pause;

    canny_raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .advance     (mem_rd),
        .addr        (addr),
        .first_pixel (first_pixel),
        .last_col    (last_col),
        .last_pixel  (last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_rd && last_col) begin
                        if (last_pixel) begin
                            state_q <= DRAIN;
                        end else if (LINE_GAP > 0) begin
                            state_q   <= GAP;
                            gap_cnt_q <= '0;
                        end
                    end
                end
                GAP: begin
                    // pause freezes the gap so the idle spacing stays exact
                    if (!pause) begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_q <= READ;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Leave once the last read has moved into the output
                    // register, so done lands one cycle after the last out_en.
                    if (!rd_p1_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_p1_d    = mem_rd;
        fs_p1_d    = mem_rd && first_pixel;
        le_p1_d    = mem_rd && last_col;
        out_en_d   = rd_p1_q;
        fs_d       = fs_p1_q;
        le_d       = le_p1_q;
        out_data_d = rd_p1_q ? bus.mem_rdata : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_p1_q    <= 1'b0;
            fs_p1_q    <= 1'b0;
            le_p1_q    <= 1'b0;
            out_en_q   <= 1'b0;
            fs_q       <= 1'b0;
            le_q       <= 1'b0;
            out_data_q <= '0;
        end else begin
            rd_p1_q    <= rd_p1_d;
            fs_p1_q    <= fs_p1_d;
            le_p1_q    <= le_p1_d;
            out_en_q   <= out_en_d;
            fs_q       <= fs_d;
            le_q       <= le_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.mem_rd      = mem_rd;
    assign bus.mem_addr    = addr;
    assign bus.out_data    = out_data_q;
    assign bus.out_en      = out_en_q;
    assign bus.frame_start = fs_q;
    assign bus.line_end    = le_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_canny_frame_streamer.sv
// ---------------------------------------------------------------------------
// tb_canny_frame_streamer
// Three streamer instances sharing one clock:
//   A: 4x3 frame, LINE_GAP=2 (timing, pause, restart-while-busy, reset abort)
//   B: 1x3 frame, LINE_GAP=0 (one-pixel lines)
//   C: 16x8 frame, LINE_GAP=0 (longer contiguous frame, counts and last address)
// Each frame buffer model returns data = address one cycle after mem_rd.
// ---------------------------------------------------------------------------
module tb_canny_frame_streamer;
    import canny_pkg::*;

    logic clk;
    logic rst;
    logic start_a, pause_a, start_b, pause_b, start_c, pause_c;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
    stream_state_e st_a, st_b, st_c;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    logic [15:0] exp_c[$];

    int en_cnt_a, done_cnt_a, en_cnt_b, done_cnt_b, en_cnt_c, done_cnt_c, le_cnt_c;
    logic [31:0] last_addr_c;

    int t1_en[12];
    int t2_en[12];

    canny_frame_streamer_if #(.DATA_W(16), .ADDR_W(4)) bus_a();
    canny_frame_streamer_if #(.DATA_W(16), .ADDR_W(2)) bus_b();
    canny_frame_streamer_if #(.DATA_W(16), .ADDR_W(7)) bus_c();

    canny_frame_streamer #(.IMG_W(4), .IMG_H(3), .DATA_W(16), .ADDR_W(4), .LINE_GAP(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pause(pause_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .dbg_state(st_a)
    );
    canny_frame_streamer #(.IMG_W(1), .IMG_H(3), .DATA_W(16), .ADDR_W(2), .LINE_GAP(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pause(pause_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .dbg_state(st_b)
    );
    canny_frame_streamer #(.IMG_W(16), .IMG_H(8), .DATA_W(16), .ADDR_W(7), .LINE_GAP(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .pause(pause_c), .bus(bus_c),
        .busy(busy_c), .done(done_c), .dbg_state(st_c)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- frame buffer models: data = address ----------------
    always @(posedge clk) if (bus_a.mem_rd) bus_a.mem_rdata <= 16'(bus_a.mem_addr);
    always @(posedge clk) if (bus_b.mem_rd) bus_b.mem_rdata <= 16'(bus_b.mem_addr);
    always @(posedge clk) if (bus_c.mem_rd) bus_c.mem_rdata <= 16'(bus_c.mem_addr);

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboards ----------------
    always @(negedge clk) begin : mon_a
        logic [15:0] e;
        if (bus_a.out_en === 1'b1) begin
            en_cnt_a = en_cnt_a + 1;
            check("a_pixel_expected", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("a_out_data", 32'(bus_a.out_data), 32'(e));
                check("a_frame_start", 32'(bus_a.frame_start), 32'(e == 16'd0));
                check("a_line_end", 32'(bus_a.line_end), 32'((e % 16'd4) == 16'd3));
            end
        end else begin
            check("a_fs_idle", 32'(bus_a.frame_start), 32'd0);
            check("a_le_idle", 32'(bus_a.line_end), 32'd0);
        end
        if (done_a === 1'b1) done_cnt_a = done_cnt_a + 1;
    end

    always @(negedge clk) begin : mon_b
        logic [15:0] e;
        if (bus_b.out_en === 1'b1) begin
            en_cnt_b = en_cnt_b + 1;
            check("b_pixel_expected", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("b_out_data", 32'(bus_b.out_data), 32'(e));
                check("b_frame_start", 32'(bus_b.frame_start), 32'(e == 16'd0));
                check("b_line_end", 32'(bus_b.line_end), 32'd1);
            end
        end
        if (done_b === 1'b1) done_cnt_b = done_cnt_b + 1;
    end

    always @(negedge clk) begin : mon_c
        logic [15:0] e;
        if (bus_c.mem_rd === 1'b1) last_addr_c = 32'(bus_c.mem_addr);
        if (bus_c.out_en === 1'b1) begin
            en_cnt_c = en_cnt_c + 1;
            if (bus_c.line_end === 1'b1) le_cnt_c = le_cnt_c + 1;
            check("c_pixel_expected", 32'(exp_c.size() > 0), 32'd1);
            if (exp_c.size() > 0) begin
                e = exp_c.pop_front();
                check("c_out_data", 32'(bus_c.out_data), 32'(e));
            end
        end
        if (done_c === 1'b1) done_cnt_c = done_cnt_c + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic load_a();
        exp_a.delete();
        for (int i = 0; i < 12; i++) exp_a.push_back(16'(i));
        en_cnt_a   = 0;
        done_cnt_a = 0;
    endtask

    // Called at a negedge (cycle 0). Start is high for cycle 0; pause is high
    // for cycles p_lo..p_hi; start is pulsed again in cycle restart_cyc.
    task automatic run_frame_a(input string name, input int en_cyc[12], input int done_cyc,
                               input int p_lo, input int p_hi, input int restart_cyc);
        logic exp_en;
        start_a = 1'b1;
        pause_a = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 1; k <= done_cyc + 2; k++) begin
            exp_en = 1'b0;
            for (int i = 0; i < 12; i++) if (en_cyc[i] == k) exp_en = 1'b1;
            check($sformatf("%s_en_c%0d", name, k), 32'(out_en_a()), 32'(exp_en));
            check($sformatf("%s_done_c%0d", name, k), 32'(done_a), 32'(k == done_cyc));
            check($sformatf("%s_busy_c%0d", name, k), 32'(busy_a), 32'(k < done_cyc));
            pause_a = (k >= p_lo) && (k <= p_hi);
            start_a = (k == restart_cyc);
            @(negedge clk);
        end
        pause_a = 1'b0;
        start_a = 1'b0;
    endtask

    function automatic logic out_en_a();
        return bus_a.out_en;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        logic found;
        rst = 1'b1;
        start_a = 1'b0; pause_a = 1'b0;
        start_b = 1'b0; pause_b = 1'b0;
        start_c = 1'b0; pause_c = 1'b0;
        en_cnt_a = 0; done_cnt_a = 0; en_cnt_b = 0; done_cnt_b = 0;
        en_cnt_c = 0; done_cnt_c = 0; le_cnt_c = 0; last_addr_c = '0;
        t1_en = '{3, 4, 5, 6, 9, 10, 11, 12, 15, 16, 17, 18};
        t2_en = '{3, 4, 5, 6, 9, 15, 16, 17, 20, 21, 22, 23};
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_en", 32'(bus_a.out_en), 32'd0);
        check("rst_mem_rd", 32'(bus_a.mem_rd), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_state", 32'(st_a), 32'(IDLE));
        check("rst_out_data", 32'(bus_a.out_data), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: plain frame with 2-cycle line gaps
        load_a();
        run_frame_a("t1", t1_en, 19, 0, -1, 0);
        check("t1_en_total", 32'(en_cnt_a), 32'd12);
        check("t1_done_total", 32'(done_cnt_a), 32'd1);
        check("t1_queue_empty", 32'(exp_a.size()), 32'd0);
        repeat (2) @(negedge clk);

        // T2: pause for cycles 8..12 in the middle of line 1
        load_a();
        run_frame_a("t2", t2_en, 24, 8, 12, 0);
        check("t2_en_total", 32'(en_cnt_a), 32'd12);
        check("t2_done_total", 32'(done_cnt_a), 32'd1);
        check("t2_queue_empty", 32'(exp_a.size()), 32'd0);
        repeat (2) @(negedge clk);

        // T3: second start while busy is ignored
        load_a();
        run_frame_a("t3", t1_en, 19, 0, -1, 5);
        repeat (5) @(negedge clk);
        check("t3_en_total", 32'(en_cnt_a), 32'd12);
        check("t3_done_total", 32'(done_cnt_a), 32'd1);
        check("t3_state_idle", 32'(st_a), 32'(IDLE));

        // T4: reset at pixel 6 aborts the frame
        load_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus_a.out_en === 1'b1 && bus_a.out_data === 16'd6) found = 1'b1;
        end
        check("t4_pixel6_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t4_abort_out_en", 32'(bus_a.out_en), 32'd0);
        check("t4_abort_busy", 32'(busy_a), 32'd0);
        check("t4_abort_state", 32'(st_a), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_no_done", 32'(done_cnt_a), 32'd0);
        load_a();
        run_frame_a("t4r", t1_en, 19, 0, -1, 0);
        check("t4_en_total", 32'(en_cnt_a), 32'd12);
        check("t4_done_total", 32'(done_cnt_a), 32'd1);

        // T5: one-pixel lines, no gap
        exp_b.delete();
        for (int i = 0; i < 3; i++) exp_b.push_back(16'(i));
        en_cnt_b = 0; done_cnt_b = 0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("t5_en_c%0d", k), 32'(bus_b.out_en), 32'((k >= 3) && (k <= 5)));
            check($sformatf("t5_done_c%0d", k), 32'(done_b), 32'(k == 6));
            @(negedge clk);
        end
        check("t5_en_total", 32'(en_cnt_b), 32'd3);
        check("t5_done_total", 32'(done_cnt_b), 32'd1);

        // T6 (scaled): 16x8 contiguous frame
        exp_c.delete();
        for (int i = 0; i < 128; i++) exp_c.push_back(16'(i));
        en_cnt_c = 0; done_cnt_c = 0; le_cnt_c = 0;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (done_c === 1'b1) found = 1'b1;
        end
        check("t6_done_seen", 32'(found), 32'd1);
        check("t6_en_total", 32'(en_cnt_c), 32'd128);
        check("t6_line_end_total", 32'(le_cnt_c), 32'd8);
        check("t6_last_addr", last_addr_c, 32'd127);
        check("t6_queue_empty", 32'(exp_c.size()), 32'd0);
        check("t6_busy_low", 32'(busy_c), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
